lasr_stim_driver: RTL and testbench



---
 rtl/lasr_stim_driver_if.sv | 39 +++
 rtl/lasr_stim_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_lasr_stim_driver.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lasr_stim_driver_if.sv
// Control/status and cell-pin bundle for the LASR latch stimulus driver.
// slave = driver side, master = run controller / cell harness side.
interface lasr_stim_driver_if #(
   parameter int unsigned LFSR_W = 16,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned EW_W   = 4,
   parameter int unsigned PER_W  = 8
);
   logic              start;
   logic [CNT_W-1:0]  n_vectors;
   logic [LFSR_W-1:0] seed;
   logic [EW_W-1:0]   en_width;
   logic [PER_W-1:0]  set_period;
   logic [PER_W-1:0]  rst_period;
   logic              dut_d;
   logic              dut_en;
   logic              dut_setb;
   logic              dut_rstb;
   logic              dut_q;
   logic              dut_qn;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  err_count;
   logic [CNT_W-1:0]  toggle_count;

   modport slave (
      input  start, n_vectors, seed, en_width, set_period, rst_period,
      input  dut_q, dut_qn,
      output dut_d, dut_en, dut_setb, dut_rstb,
      output busy, done, err_count, toggle_count
   );

   modport master (
      output start, n_vectors, seed, en_width, set_period, rst_period,
      output dut_q, dut_qn,
      input  dut_d, dut_en, dut_setb, dut_rstb,
      input  busy, done, err_count, toggle_count
   );
endinterface

// File: rtl/lasr_stim_driver.sv
// Stimulus driver / checker for active-low set/reset latch cells: sequences D, EN,
// SETB and RSTB one pin per edge, checks Q/QN against a reference, counts errors and toggles.
module lasr_stim_driver #(
   parameter int unsigned LFSR_W = 16,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned EW_W   = 4,
   parameter int unsigned PER_W  = 8
) (
   input  logic              CLK,
   input  logic              RSTB,
   lasr_stim_driver_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_ALO   = 3'd4;
   localparam logic [2:0] S_AREC  = 3'd5;
   localparam logic [2:0] S_CHECK = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);
   localparam logic [LFSR_W-1:0] SEED_DEF  = LFSR_W'(16'hACE1);

   logic [2:0]        r_state;
   logic [LFSR_W-1:0] r_lfsr;
   logic [CNT_W-1:0]  r_nvec;
   logic [CNT_W-1:0]  r_vec;
   logic [EW_W-1:0]   r_ew;
   logic [EW_W-1:0]   r_ew_cnt;
   logic [PER_W-1:0]  r_set_per;
   logic [PER_W-1:0]  r_rst_per;
   logic [PER_W-1:0]  r_set_ph;
   logic [PER_W-1:0]  r_rst_ph;
   logic              r_async_rst;
   logic              r_async_cnt;
   logic              r_q_exp;
   logic              r_prev_q;
   logic              r_dut_d;
   logic              r_dut_en;
   logic              r_dut_setb;
   logic              r_dut_rstb;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  r_err;
   logic [CNT_W-1:0]  r_tog;

   logic [LFSR_W-1:0] w_seed;
   logic [LFSR_W-1:0] w_lfsr_src;
   logic [LFSR_W-1:0] w_lfsr_nxt;
   logic [EW_W-1:0]   w_ew;
   logic              w_rst_due;
   logic              w_set_due;
   logic [PER_W-1:0]  w_rst_ph_nxt;
   logic [PER_W-1:0]  w_set_ph_nxt;
   logic [CNT_W-1:0]  w_vec_nxt;
   logic              w_match;
   logic              w_start_ok;

   assign w_seed     = (bus.seed == '0) ? SEED_DEF : bus.seed;
   assign w_lfsr_src = (r_state == S_IDLE) ? w_seed : r_lfsr;
   assign w_lfsr_nxt = (w_lfsr_src >> 1) ^ (w_lfsr_src[0] ? LFSR_TAPS : '0);
   assign w_ew       = (bus.en_width == '0) ? EW_W'(1) : bus.en_width;

   // Phase counters hold vec mod period, so "due" is phase == period-1.
   assign w_rst_due    = (r_rst_per != '0) && (r_rst_ph == r_rst_per - 1'b1);
   assign w_set_due    = (r_set_per != '0) && (r_set_ph == r_set_per - 1'b1);
   assign w_rst_ph_nxt = w_rst_due ? '0 : r_rst_ph + 1'b1;
   assign w_set_ph_nxt = w_set_due ? '0 : r_set_ph + 1'b1;
   assign w_vec_nxt    = r_vec + 1'b1;

   // An unknown Q/QN evaluates the match as X, which falls to the error branch.
   assign w_match = (bus.dut_q == r_q_exp) && (bus.dut_qn == ~r_q_exp);

   // Start is held off until the cell has left reset so the release and the
   // first D change never share an edge.
   assign w_start_ok = bus.start && r_dut_rstb;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         r_state     <= S_IDLE;
         r_lfsr      <= '0;
         r_nvec      <= '0;
         r_vec       <= '0;
         r_ew        <= '0;
         r_ew_cnt    <= '0;
         r_set_per   <= '0;
         r_rst_per   <= '0;
         r_set_ph    <= '0;
         r_rst_ph    <= '0;
         r_async_rst <= 1'b0;
         r_async_cnt <= 1'b0;
         r_q_exp     <= 1'b0;
         r_prev_q    <= 1'b0;
         r_dut_d     <= 1'b0;
         r_dut_en    <= 1'b0;
         r_dut_setb  <= 1'b1;
         r_dut_rstb  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= '0;
         r_tog       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_dut_rstb <= 1'b1;
               if (w_start_ok) begin
                  r_nvec    <= bus.n_vectors;
                  r_ew      <= w_ew;
                  r_set_per <= bus.set_period;
                  r_rst_per <= bus.rst_period;
                  r_set_ph  <= '0;
                  r_rst_ph  <= '0;
                  r_vec     <= '0;
                  r_err     <= '0;
                  r_tog     <= '0;
                  r_prev_q  <= 1'b0;
                  if (bus.n_vectors == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_busy  <= 1'b1;
                     r_dut_d <= w_seed[0];
                     r_lfsr  <= w_lfsr_nxt;
                     r_state <= S_SETUP;
                  end
               end
            end

            S_SETUP: begin
               r_dut_en <= 1'b1;
               r_q_exp  <= r_dut_d;
               r_ew_cnt <= r_ew - 1'b1;
               r_state  <= S_PULSE;
            end

            S_PULSE: begin
               if (r_ew_cnt == '0) begin
                  r_dut_en <= 1'b0;
                  r_state  <= S_HOLD;
               end else begin
                  r_ew_cnt <= r_ew_cnt - 1'b1;
               end
            end

            S_HOLD: begin
               r_async_cnt <= 1'b1;
               if (w_rst_due) begin
                  r_dut_rstb  <= 1'b0;
                  r_async_rst <= 1'b1;
                  r_q_exp     <= 1'b0;
                  r_state     <= S_ALO;
               end else if (w_set_due) begin
                  r_dut_setb  <= 1'b0;
                  r_async_rst <= 1'b0;
                  r_q_exp     <= 1'b1;
                  r_state     <= S_ALO;
               end else begin
                  r_state <= S_CHECK;
               end
            end

            S_ALO: begin
               if (r_async_cnt) begin
                  r_async_cnt <= 1'b0;
               end else begin
                  if (r_async_rst) r_dut_rstb <= 1'b1;
                  else             r_dut_setb <= 1'b1;
                  r_state <= S_AREC;
               end
            end

            S_AREC: begin
               r_state <= S_CHECK;
            end

            S_CHECK: begin
               if (w_match) begin
                  r_err <= r_err;
               end else if (r_err != '1) begin
                  r_err <= r_err + 1'b1;
               end
               if ((bus.dut_q != r_prev_q) && (r_tog != '1)) begin
                  r_tog <= r_tog + 1'b1;
               end
               r_prev_q <= bus.dut_q;
               r_vec    <= w_vec_nxt;
               r_rst_ph <= w_rst_ph_nxt;
               r_set_ph <= w_set_ph_nxt;
               if (w_vec_nxt == r_nvec) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_dut_d <= r_lfsr[0];
                  r_lfsr  <= w_lfsr_nxt;
                  r_state <= S_SETUP;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.dut_d        = r_dut_d;
   assign bus.dut_en       = r_dut_en;
   assign bus.dut_setb     = r_dut_setb;
   assign bus.dut_rstb     = r_dut_rstb;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.err_count    = r_err;
   assign bus.toggle_count = r_tog;

endmodule

// File: tb/tb_lasr_stim_driver.sv
// Directed, table-driven bench for lasr_stim_driver with a behavioural LASR cell
// model and fault injection (Q stuck-at-0, QN forced unknown on one check).
module tb_lasr_stim_driver;
   localparam int unsigned LFSR_W = 16;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned EW_W   = 4;
   localparam int unsigned PER_W  = 8;
   localparam int unsigned TMO    = 3000;

   logic CLK  = 1'b0;
   logic RSTB = 1'b0;
   always #5 CLK = ~CLK;

   lasr_stim_driver_if #(.LFSR_W(LFSR_W), .CNT_W(CNT_W), .EW_W(EW_W), .PER_W(PER_W)) bus ();

   lasr_stim_driver #(.LFSR_W(LFSR_W), .CNT_W(CNT_W), .EW_W(EW_W), .PER_W(PER_W)) dut (
      .CLK  (CLK),
      .RSTB (RSTB),
      .bus  (bus)
   );

   typedef struct {
      logic [15:0]  n;
      logic [15:0]  seed;
      logic [3:0]   ew;
      logic [7:0]   setp;
      logic [7:0]   rstp;
      bit           stuck;
      bit           xm;
      int unsigned  busy_cyc;
      int unsigned  err;
      int unsigned  tog;
      int unsigned  en_cyc;
      int unsigned  lo_cyc;
      logic [31:0]  rmask;
      logic [31:0]  smask;
      logic [31:0]  dmask;
   } vec_t;

   vec_t        tbl[5];
   int unsigned n_assert;
   int unsigned n_fail;
   bit          stuck0;
   bit          x_mode;

   // Ideal active-low set/reset latch; reset dominates set.
   logic cell_q;
   always_latch begin
      if (!bus.dut_rstb)      cell_q = 1'b0;
      else if (!bus.dut_setb) cell_q = 1'b1;
      else if (bus.dut_en)    cell_q = bus.dut_d;
   end

   int unsigned m_busy, m_done, m_en_cyc, m_lo, m_vec, m_multi;
   logic [31:0] m_rmask, m_smask, m_dmask;
   logic        p_d, p_en, p_s, p_r;

   assign bus.dut_q  = stuck0 ? 1'b0 : cell_q;
   assign bus.dut_qn = (x_mode && (m_vec == 3) && !bus.dut_en) ? 1'bx : ~cell_q;

   // Monitor: per-run activity, cleared on the cycle start is presented.
   always @(negedge CLK) begin
      if (bus.start) begin
         m_busy <= 0; m_done <= 0; m_en_cyc <= 0; m_lo <= 0; m_vec <= 0; m_multi <= 0;
         m_rmask <= '0; m_smask <= '0; m_dmask <= '0;
      end else begin
         if (bus.busy)   m_busy   <= m_busy + 1;
         if (bus.done)   m_done   <= m_done + 1;
         if (bus.dut_en) m_en_cyc <= m_en_cyc + 1;
         if (bus.busy && (!bus.dut_rstb || !bus.dut_setb)) m_lo <= m_lo + 1;
         if (bus.dut_en && !p_en) begin
            if (bus.dut_d) m_dmask[m_vec] <= 1'b1;
            m_vec <= m_vec + 1;
         end
         if (bus.busy && !bus.dut_rstb && p_r && m_vec > 0) m_rmask[m_vec-1] <= 1'b1;
         if (bus.busy && !bus.dut_setb && p_s && m_vec > 0) m_smask[m_vec-1] <= 1'b1;
         if ((int'(bus.dut_d != p_d) + int'(bus.dut_en != p_en) +
              int'(bus.dut_setb != p_s) + int'(bus.dut_rstb != p_r)) > 1 && bus.busy)
            m_multi <= m_multi + 1;
      end
      p_d  <= bus.dut_d;
      p_en <= bus.dut_en;
      p_s  <= bus.dut_setb;
      p_r  <= bus.dut_rstb;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] n, input logic [15:0] seed, input logic [3:0] ew,
                               input logic [7:0] setp, input logic [7:0] rstp,
                               input bit stuck, input bit xm,
                               input int unsigned busy_cyc, input int unsigned err,
                               input int unsigned tog, input int unsigned en_cyc,
                               input int unsigned lo_cyc, input logic [31:0] rmask,
                               input logic [31:0] smask, input logic [31:0] dmask);
      vec_t v;
      v.n = n; v.seed = seed; v.ew = ew; v.setp = setp; v.rstp = rstp;
      v.stuck = stuck; v.xm = xm; v.busy_cyc = busy_cyc; v.err = err; v.tog = tog;
      v.en_cyc = en_cyc; v.lo_cyc = lo_cyc; v.rmask = rmask; v.smask = smask; v.dmask = dmask;
      return v;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, " dut_d"},    32'(bus.dut_d),        32'd0);
      chk({tag, " dut_en"},   32'(bus.dut_en),       32'd0);
      chk({tag, " dut_setb"}, 32'(bus.dut_setb),     32'd1);
      chk({tag, " dut_rstb"}, 32'(bus.dut_rstb),     32'd0);
      chk({tag, " busy"},     32'(bus.busy),         32'd0);
      chk({tag, " done"},     32'(bus.done),         32'd0);
      chk({tag, " err"},      32'(bus.err_count),    32'd0);
      chk({tag, " toggle"},   32'(bus.toggle_count), 32'd0);
   endtask

   task automatic start_run(input vec_t v);
      @(posedge CLK); #1;
      stuck0         = v.stuck;
      x_mode         = v.xm;
      bus.n_vectors  = v.n;
      bus.seed       = v.seed;
      bus.en_width   = v.ew;
      bus.set_period = v.setp;
      bus.rst_period = v.rstp;
      bus.start      = 1'b1;
      @(posedge CLK); #1;
      bus.start      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int unsigned t = 0;
      while (bus.done !== 1'b1 && t < TMO) begin
         @(negedge CLK);
         t++;
      end
      n_assert++;
      if (t >= TMO) begin
         n_fail++;
         $display("FAIL %s done-timeout: actual=no done required=done within %0d cycles", tag, TMO);
      end
      repeat (3) @(negedge CLK);
      #1;
   endtask

   task automatic apply(input int idx);
      vec_t  v;
      string tag;
      v   = tbl[idx];
      tag = $sformatf("row%0d", idx);
      start_run(v);
      wait_done(tag);
      chk({tag, " busy_cycles"}, m_busy,   v.busy_cyc);
      chk({tag, " done_pulses"}, m_done,   32'd1);
      chk({tag, " err_count"},   32'(bus.err_count),    v.err);
      chk({tag, " toggle"},      32'(bus.toggle_count), v.tog);
      chk({tag, " en_cycles"},   m_en_cyc, v.en_cyc);
      chk({tag, " async_low"},   m_lo,     v.lo_cyc);
      chk({tag, " rst_vecs"},    m_rmask,  v.rmask);
      chk({tag, " set_vecs"},    m_smask,  v.smask);
      chk({tag, " d_bits"},      m_dmask,  v.dmask);
      chk({tag, " multi_pin"},   m_multi,  32'd0);
      chk({tag, " vectors"},     m_vec,    32'(v.n));
      stuck0 = 1'b0;
      x_mode = 1'b0;
   endtask

   initial begin
      int unsigned t;
      vec_t        v0;
      n_assert = 0;
      n_fail   = 0;
      stuck0   = 1'b0;
      x_mode   = 1'b0;
      bus.start = 1'b0; bus.n_vectors = '0; bus.seed = '0; bus.en_width = '0;
      bus.set_period = '0; bus.rst_period = '0;

      // LFSR (seed 0001): D = 1,0,0,0,0,0...; (seed ACE1): D = 1,0,0,0,0,1,1,1
      tbl[0] = mk(16'd4, 16'h0001, 4'd2, 8'd0, 8'd0, 1'b0, 1'b0, 20, 0, 2,  8, 0, 32'h0,  32'h0,  32'h01);
      tbl[1] = mk(16'd6, 16'h0001, 4'd2, 8'd3, 8'd2, 1'b0, 1'b0, 42, 0, 4, 12, 8, 32'h2A, 32'h04, 32'h01);
      tbl[2] = mk(16'd8, 16'hACE1, 4'd1, 8'd0, 8'd0, 1'b1, 1'b0, 32, 4, 0,  8, 0, 32'h0,  32'h0,  32'hE1);
      tbl[3] = mk(16'd4, 16'h0001, 4'd3, 8'd0, 8'd0, 1'b0, 1'b1, 24, 1, 2, 12, 0, 32'h0,  32'h0,  32'h01);
      tbl[4] = mk(16'd2, 16'h0001, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0,  8, 0, 2,  2, 0, 32'h0,  32'h0,  32'h01);

      #12;
      chk_reset("reset");
      @(negedge CLK); RSTB = 1'b1;
      @(posedge CLK); #1;
      chk("cell_release dut_rstb", 32'(bus.dut_rstb), 32'd1);

      for (int i = 0; i < 5; i++) apply(i);

      // n_vectors = 0: done on the cycle after start, busy never set.
      v0 = mk(16'd0, 16'h0001, 4'd2, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      start_run(v0);
      chk("zero done", 32'(bus.done), 32'd1);
      chk("zero busy", 32'(bus.busy), 32'd0);
      @(posedge CLK); #1;
      chk("zero done_drop", 32'(bus.done), 32'd0);
      repeat (3) @(negedge CLK); #1;
      chk("zero busy_cycles", m_busy, 32'd0);
      chk("zero done_pulses", m_done, 32'd1);

      // Abort by RSTB while vector 2 is in its enable pulse.
      start_run(tbl[0]);
      t = 0;
      while (!(m_vec == 2 && bus.dut_en) && t < TMO) begin
         @(negedge CLK); #1;
         t++;
      end
      chk("abort reached_pulse2", 32'(bus.dut_en), 32'd1);
      RSTB = 1'b0;
      #1;
      chk_reset("abort");
      @(negedge CLK); RSTB = 1'b1;
      repeat (20) @(negedge CLK); #1;
      chk("abort no_done", m_done, 32'd0);
      chk("abort idle_busy", 32'(bus.busy), 32'd0);
      chk("abort cell_release", 32'(bus.dut_rstb), 32'd1);
      apply(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global-timeout: actual=still running required=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
